// File: rtl/jtkunio_obj_scan.sv
// Per-line sprite scheduler: walks the object table from entry 31 down to 0,
// fetches 4bpp rows for objects crossing the line and paints opaque pixels into the line buffer.
module jtkunio_obj_scan #(
    parameter int OBJMAX = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [7:0]  vrender,
    input  logic        flip,
    output logic [5:0]  scan_addr,
    input  logic [15:0] scan_dout,
    output logic        rom_cs,
    output logic [17:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic        buf_we,
    output logic [7:0]  buf_addr,
    output logic [6:0]  buf_data,
    output logic        busy
);
    localparam logic [4:0] NLAST = 5'(OBJMAX - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CHK  = 3'd3,
        ROM  = 3'd4,
        DRAW = 3'd5,
        NEXT = 3'd6
    } state_t;

    // Tall objects are two stacked 16x16 tiles: the row's bit 4 selects the tile via code bit 0
    function automatic logic [17:0] row_addr(input logic [10:0] code, input logic tall,
                                             input logic [4:0] row, input logic fetch_half);
        logic [10:0] tile;
        tile = tall ? {code[10:1], row[4]} : code;
        return {tile, row[3:0], fetch_half, 2'b00};
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  n_r, n_s;
    logic        half_r, half_s;
    logic [2:0]  pix_r, pix_s;
    logic [15:0] word0_r, word0_s;
    logic [15:0] word1_r, word1_s;
    logic [31:0] data_r, data_s;
    logic [4:0]  row_r, row_s;
    logic [5:0]  scan_addr_r, scan_addr_s;
    logic        rom_cs_r, rom_cs_s;
    logic [17:0] rom_addr_r, rom_addr_s;
    logic        buf_we_r, buf_we_s;
    logic [7:0]  buf_addr_r, buf_addr_s;
    logic [6:0]  buf_data_r, buf_data_s;
    logic        busy_r, busy_s;

    logic [7:0]  ydiff_s;
    logic        hit_s;
    logic        hflip_s;
    logic        tall_s;
    logic [3:0]  col_s;
    logic [3:0]  nib_s;
    logic [7:0]  pos_s;

    assign ydiff_s = vrender - word0_r[7:0];
    assign tall_s  = word0_r[11];
    assign hflip_s = word0_r[12];
    assign hit_s   = (word0_r[7:0] != 8'd0) && (ydiff_s < (tall_s ? 8'd32 : 8'd16));
    // Mirrored column is 15-c, which is just the bitwise complement of c
    assign col_s   = {half_r, pix_r} ^ {4{hflip_s}};
    assign nib_s   = 4'(data_r >> {col_s[2:0], 2'b00});
    assign pos_s   = word1_r[7:0] + {4'd0, col_s};

    // Next-state and next-output logic
    always_comb begin
        state_s     = state_r;
        n_s         = n_r;
        half_s      = half_r;
        pix_s       = pix_r;
        word0_s     = word0_r;
        word1_s     = word1_r;
        data_s      = data_r;
        row_s       = row_r;
        scan_addr_s = scan_addr_r;
        rom_cs_s    = rom_cs_r;
        rom_addr_s  = rom_addr_r;
        buf_we_s    = 1'b0;
        buf_addr_s  = buf_addr_r;
        buf_data_s  = buf_data_r;
        busy_s      = busy_r;
        case (state_r)
            IDLE: begin
                state_s = IDLE;
            end
            RD0: begin
                scan_addr_s = {n_r, 1'b1};
                state_s     = RD1;
            end
            RD1: begin
                word0_s = scan_dout;
                state_s = CHK;
            end
            CHK: begin
                word1_s = scan_dout;
                row_s   = ydiff_s[4:0];
                if (hit_s) begin
                    half_s     = 1'b0;
                    rom_cs_s   = 1'b1;
                    rom_addr_s = row_addr({word0_r[10:8], scan_dout[15:8]}, tall_s,
                                          ydiff_s[4:0], hflip_s);
                    state_s    = ROM;
                end else begin
                    state_s = NEXT;
                end
            end
            ROM: begin
                if (rom_ok) begin
                    data_s   = rom_data;
                    rom_cs_s = 1'b0;
                    pix_s    = 3'd0;
                    state_s  = DRAW;
                end else begin
                    rom_cs_s = 1'b1;
                end
            end
            DRAW: begin
                buf_we_s   = (nib_s != 4'd0);
                buf_addr_s = flip ? ~pos_s : pos_s;
                buf_data_s = {word0_r[15:13], nib_s};
                pix_s      = pix_r + 3'd1;
                if (pix_r == 3'd7) begin
                    if (!half_r) begin
                        half_s     = 1'b1;
                        rom_cs_s   = 1'b1;
                        rom_addr_s = row_addr({word0_r[10:8], word1_r[15:8]}, tall_s,
                                              row_r, ~hflip_s);
                        state_s    = ROM;
                    end else begin
                        state_s = NEXT;
                    end
                end else begin
                    state_s = DRAW;
                end
            end
            NEXT: begin
                if (n_r == 5'd0) begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    n_s         = n_r - 5'd1;
                    scan_addr_s = {n_r - 5'd1, 1'b0};
                    state_s     = RD0;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // A new line always wins, even in the middle of an object
        if (line_start) begin
            state_s     = RD0;
            n_s         = NLAST;
            half_s      = 1'b0;
            busy_s      = 1'b1;
            rom_cs_s    = 1'b0;
            buf_we_s    = 1'b0;
            scan_addr_s = {NLAST, 1'b0};
        end else begin
            busy_s = busy_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            n_r         <= NLAST;
            half_r      <= 1'b0;
            pix_r       <= 3'd0;
            word0_r     <= 16'd0;
            word1_r     <= 16'd0;
            data_r      <= 32'd0;
            row_r       <= 5'd0;
            scan_addr_r <= 6'd0;
            rom_cs_r    <= 1'b0;
            rom_addr_r  <= 18'd0;
            buf_we_r    <= 1'b0;
            buf_addr_r  <= 8'd0;
            buf_data_r  <= 7'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            n_r         <= n_s;
            half_r      <= half_s;
            pix_r       <= pix_s;
            word0_r     <= word0_s;
            word1_r     <= word1_s;
            data_r      <= data_s;
            row_r       <= row_s;
            scan_addr_r <= scan_addr_s;
            rom_cs_r    <= rom_cs_s;
            rom_addr_r  <= rom_addr_s;
            buf_we_r    <= buf_we_s;
            buf_addr_r  <= buf_addr_s;
            buf_data_r  <= buf_data_s;
            busy_r      <= busy_s;
        end
    end

    assign scan_addr = scan_addr_r;
    assign rom_cs    = rom_cs_r;
    assign rom_addr  = rom_addr_r;
    assign buf_we    = buf_we_r;
    assign buf_addr  = buf_addr_r;
    assign buf_data  = buf_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_jtkunio_obj_scan.sv
// Bench for jtkunio_obj_scan: RAM/ROM responders plus a per-line reference painter
// that computes the final line buffer and ROM fetch order straight from the object rules.
module tb_jtkunio_obj_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  vrender = 8'd0;
    logic        flip = 1'b0;
    logic [5:0]  scan_addr;
    logic [15:0] scan_dout = 16'd0;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data = 32'd0;
    logic        rom_ok = 1'b0;
    logic        buf_we;
    logic [7:0]  buf_addr;
    logic [6:0]  buf_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] ram [0:63];
    logic [7:0]  lb  [0:255];
    logic [7:0]  mlb [0:255];
    int          wcount = 0;
    int          mcount = 0;
    logic [17:0] got_addr [$];
    logic [17:0] exp_addr [$];
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_word = 32'd0;
    int          stall_len = 0;
    int          stall_cnt = 0;
    logic [5:0]  addr_d = 6'd0;
    logic [17:0] a0;

    jtkunio_obj_scan dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .vrender(vrender), .flip(flip),
        .scan_addr(scan_addr), .scan_dout(scan_dout), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_data(buf_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        logic [31:0] h;
        logic [31:0] r;
        if (fixed_en) return fixed_word;
        h = {14'd0, a} * 32'h9E3779B1 + 32'h7F4A7C15;
        h = h ^ (h >> 15);
        r = h;
        for (int i = 0; i < 8; i++)
            if (h[4*i +: 2] == 2'b00) r[4*i +: 4] = 4'd0;
        return r;
    endfunction

    // RAM with one clock of read latency, ROM slot with programmable stall, line buffer capture
    always @(negedge clk) begin
        scan_dout = ram[addr_d];
        addr_d = scan_addr;
        if (buf_we) begin
            lb[buf_addr] = {1'b1, buf_data};
            wcount++;
        end
        if (!rom_cs) begin
            rom_ok = 1'b0;
            stall_cnt = 0;
        end else if (!rom_ok) begin
            if (stall_cnt >= stall_len) begin
                rom_ok = 1'b1;
                rom_data = rom_word(rom_addr);
                got_addr.push_back(rom_addr);
            end else begin
                stall_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_line(input logic [7:0] vr, input logic fl);
        logic [15:0] w0, w1;
        logic [7:0]  y, yd, x, pos;
        logic [10:0] code;
        logic        tall, hf;
        int          cp;
        logic [17:0] wa;
        logic [31:0] w;
        logic [3:0]  px;
        for (int a = 0; a < 256; a++) mlb[a] = 8'd0;
        mcount = 0;
        exp_addr.delete();
        for (int o = 31; o >= 0; o--) begin
            w0 = ram[2*o];
            w1 = ram[2*o+1];
            y = w0[7:0];
            x = w1[7:0];
            tall = w0[11];
            hf = w0[12];
            code = {w0[10:8], w1[15:8]};
            yd = vr - y;
            if (y != 8'd0 && yd < (tall ? 8'd32 : 8'd16)) begin
                if (tall) code[0] = yd[4];
                for (int c = 0; c < 16; c++) begin
                    cp = hf ? 15 - c : c;
                    wa = {code, yd[3:0], (cp >= 8) ? 1'b1 : 1'b0, 2'b00};
                    if (c % 8 == 0) exp_addr.push_back(wa);
                    w = rom_word(wa);
                    px = w[4*(cp%8) +: 4];
                    if (px != 4'd0) begin
                        pos = x + 8'(cp);
                        if (fl) pos = ~pos;
                        mlb[pos] = {1'b1, w0[15:13], px};
                        mcount++;
                    end
                end
            end
        end
    endtask

    task automatic clear_capture();
        for (int a = 0; a < 256; a++) lb[a] = 8'd0;
        wcount = 0;
        got_addr.delete();
    endtask

    task automatic start_line(input logic [7:0] vr, input logic fl);
        clear_capture();
        vrender = vr;
        flip = fl;
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
    endtask

    task automatic finish_line(input string tag);
        int cyc;
        logic [17:0] g;
        cyc = 0;
        while (busy && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".done"}, busy, 1'b0);
        model_line(vrender, flip);
        chk({tag, ".writes"}, wcount, mcount);
        chk({tag, ".nfetch"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < got_addr.size()) g = got_addr[i];
            else g = 18'h3FFFF;
            chk({tag, ".fetch"}, g, exp_addr[i]);
        end
        for (int a = 0; a < 256; a++) chk({tag, ".pix"}, lb[a], mlb[a]);
    endtask

    task automatic wait_rom_cs(input string tag);
        int cyc;
        cyc = 0;
        while (!rom_cs && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".romcs"}, rom_cs, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'd0;
        #23;
        chk("reset.busy", busy, 1'b0);
        chk("reset.romcs", rom_cs, 1'b0);
        chk("reset.we", buf_we, 1'b0);
        chk("reset.scan", scan_addr, 6'd0);
        chk("reset.romaddr", rom_addr, 18'd0);
        chk("reset.bufaddr", buf_addr, 8'd0);
        chk("reset.bufdata", buf_data, 7'd0);
        @(negedge clk) rst_n = 1'b1;

        // single hit on object 5
        fixed_en = 1'b1;
        fixed_word = 32'h76543210;
        ram[10] = {8'h41, 8'h20};
        ram[11] = {8'h23, 8'h40};
        start_line(8'h25, 1'b0);
        finish_line("hit");
        a0 = (got_addr.size() > 0) ? got_addr[0] : 18'h3FFFF;
        chk("hit.addr0", a0, {11'h123, 4'h5, 1'b0, 2'b00});
        chk("hit.x40", lb[8'h40], 8'h00);
        chk("hit.x41", lb[8'h41], 8'hA1);
        chk("hit.x47", lb[8'h47], 8'hA7);

        // hflip and screen flip
        ram[10] = {8'h51, 8'h20};
        start_line(8'h25, 1'b1);
        finish_line("hflip");
        a0 = (got_addr.size() > 0) ? got_addr[0] : 18'h3FFFF;
        chk("hflip.addr0", a0, {11'h123, 4'h5, 1'b1, 2'b00});
        chk("hflip.xB0", lb[8'hB0], 8'hA7);
        chk("hflip.xB7", lb[8'hB7], 8'h00);

        // tall object wrapping across line 0
        ram[10] = {8'h49, 8'hF0};
        ram[11] = {8'h22, 8'h40};
        start_line(8'h05, 1'b0);
        finish_line("tall");
        a0 = (got_addr.size() > 0) ? got_addr[0] : 18'h3FFFF;
        chk("tall.addr0", a0, {11'h123, 4'h5, 1'b0, 2'b00});
        ram[10] = {8'h41, 8'hF0};
        start_line(8'h05, 1'b0);
        finish_line("short");
        chk("short.nfetch", got_addr.size(), 0);

        // ROM stall: request must hold steady
        ram[10] = {8'h41, 8'h20};
        ram[11] = {8'h23, 8'h40};
        stall_len = 20;
        start_line(8'h25, 1'b0);
        wait_rom_cs("stall");
        a0 = rom_addr;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            chk("stall.cs", rom_cs, 1'b1);
            chk("stall.addr", rom_addr, a0);
            chk("stall.we", buf_we, 1'b0);
        end
        finish_line("stall");

        // abort during ROM wait
        stall_len = 40;
        start_line(8'h25, 1'b0);
        wait_rom_cs("abort");
        @(negedge clk) line_start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.cs", rom_cs, 1'b0);
        chk("abort.scan", scan_addr, 6'd62);
        chk("abort.busy", busy, 1'b1);
        @(negedge clk) line_start = 1'b0;
        stall_len = 0;
        finish_line("abort");

        // randomized tables
        fixed_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] vr;
            logic [7:0] y;
            vr = 8'($urandom);
            for (int o = 0; o < 32; o++) begin
                y = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'(vr - 8'($urandom_range(0, 40)));
                ram[2*o]   = {8'($urandom), y};
                ram[2*o+1] = 16'($urandom);
            end
            stall_len = $urandom_range(0, 3);
            start_line(vr, 1'($urandom));
            finish_line("rand");
        end

        // asynchronous reset in the middle of drawing
        for (int i = 0; i < 64; i++) ram[i] = 16'd0;
        fixed_en = 1'b1;
        ram[10] = {8'h41, 8'h20};
        ram[11] = {8'h23, 8'h40};
        stall_len = 0;
        start_line(8'h25, 1'b0);
        begin
            int cyc;
            cyc = 0;
            while (!buf_we && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            chk("rstdraw.we_seen", buf_we, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rstdraw.we", buf_we, 1'b0);
        chk("rstdraw.cs", rom_cs, 1'b0);
        chk("rstdraw.busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        clear_capture();
        @(negedge clk) line_start = 1'b1;
        @(posedge clk);
        #1;
        chk("rstdraw.scan", scan_addr, 6'd62);
        chk("rstdraw.busy1", busy, 1'b1);
        @(negedge clk) line_start = 1'b0;
        finish_line("rstdraw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
